// File: rtl/acc_fed_pkg.sv
// Shared constants for the multi-channel accumulator.
// Build option: define ACC_FED_SAT_EN to saturate on overflow instead of wrapping.
package acc_fed_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

`ifdef ACC_FED_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/acc_fed_lane.sv
// One accumulator channel: register, adder, overflow policy and sticky flag.
// nxt_o is the value the register takes at the coming edge, so the top can
// register it as the result without a second add.
module acc_fed_lane
  import acc_fed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             add_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  // Next-state: clear (optionally loading din) beats a plain accumulate.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, din_i};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = add_i ? din_i : '0;
      ovf_d = 1'b0;
    end else if (add_i) begin
      ovf_d = ovf_q | sum[WIDTH];
      if (sum[WIDTH] && SAT_EN) acc_d = '1;
      else                      acc_d = sum[WIDTH-1:0];
    end
  end

  // Channel state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign nxt_o = acc_d;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_fed_multi.sv
// Multi-channel accumulator: decodes in_ch to one lane, registers that
// lane's updated value as the single-cycle-latency result.
// Build option: ACC_FED_SAT_EN selects saturating overflow (default wraps).
module acc_fed_multi
  import acc_fed_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                in_valid,
  input  logic [CHW-1:0]      in_ch,
  input  logic [WIDTH-1:0]    din,
  input  logic                clr,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic [WIDTH-1:0]    dout,
  output logic [CHANNELS-1:0] ovf
);

  logic                           hit;
  logic [CHANNELS-1:0]            sel;
  logic [CHANNELS-1:0][WIDTH-1:0] nxt;
  logic [WIDTH-1:0]               mux;

  logic             out_valid_q;
  logic [CHW-1:0]   out_ch_q;
  logic [WIDTH-1:0] dout_q;

  // Indices past the last channel are dropped entirely.
  assign hit = 32'(in_ch) < 32'(CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign sel[g] = hit && (in_ch == CHW'(g));
    acc_fed_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .res   (res),
      .add_i (in_valid && sel[g]),
      .clr_i (clr && sel[g]),
      .din_i (din),
      .nxt_o (nxt[g]),
      .ovf_o (ovf[g])
    );
  end

  // Select the addressed lane's next value (one-hot sel).
  always_comb begin
    mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel[i]) mux = nxt[i];
  end

  // Result register: dout/out_ch hold between results.
  always_ff @(posedge clk) begin
    if (!res) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      dout_q      <= '0;
    end else begin
      out_valid_q <= in_valid && hit;
      if (in_valid && hit) begin
        out_ch_q <= in_ch;
        dout_q   <= mux;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_acc_fed_multi.sv
// Self-checking bench for acc_fed_multi: directed cases then random traffic
// against an arithmetic reference model. CHW is widened to 3 so that
// out-of-range channel indices can be driven.
module tb_acc_fed_multi;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int CW = 3;
`ifdef ACC_FED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ch = '0;
  logic [W-1:0]  din = '0;
  logic          clr = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  dout;
  logic [CH-1:0] ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int unsigned m_acc [CH];
  bit          m_ovf [CH];
  bit          e_vld;
  int unsigned e_dout, e_ch;

  acc_fed_multi #(.WIDTH(W), .CHANNELS(CH), .CHW(CW)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ch(in_ch), .din(din),
    .clr(clr), .out_valid(out_valid), .out_ch(out_ch), .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ovf_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < CH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // One clock: apply inputs, advance the model, check all outputs after the edge.
  task automatic step(input bit r, input bit v, input bit c, input int ch, input int d);
    int unsigned s;
    logic [31:0] dv;
    dv = d;
    res = r; in_valid = v; clr = c; in_ch = ch[CW-1:0]; din = dv[W-1:0];
    if (!r) begin
      for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
      e_vld = 0; e_dout = 0; e_ch = 0;
    end else if (ch < CH) begin
      if (c) begin
        m_acc[ch] = v ? dv[W-1:0] : 0;
        m_ovf[ch] = 0;
      end else if (v) begin
        s = m_acc[ch] + dv[W-1:0];
        if (s >= (1 << W)) begin
          m_ovf[ch] = 1;
          m_acc[ch] = SAT ? (1 << W) - 1 : s - (1 << W);
        end else m_acc[ch] = s;
      end
      e_vld = v;
      if (v) begin e_dout = m_acc[ch]; e_ch = ch; end
    end else e_vld = 0;
    @(posedge clk); #1;
    chk("out_valid", out_valid, e_vld);
    chk("dout", dout, e_dout);
    chk("out_ch", out_ch, e_ch);
    chk("ovf", ovf, m_ovf_vec());
  endtask

  initial begin
    // reset
    step(0, 1, 0, 0, 123);
    step(0, 0, 0, 0, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);

    // ch0 12 then 10
    step(1, 1, 0, 0, 12); chk("r28_a", dout, 12);
    step(1, 1, 0, 0, 10); chk("r28_b", dout, 22);
    // interleave ch1/ch2
    step(1, 1, 0, 1, 5);
    step(1, 1, 0, 2, 7);
    step(1, 1, 0, 1, 3); chk("r29_ch1", dout, 8);
    step(1, 1, 0, 0, 0); chk("r29_ch0", dout, 22);
    // overflow on ch3
    step(1, 1, 1, 3, 'hFFF0);
    step(1, 1, 0, 3, 'h0020);
    chk("r30_dout", dout, SAT ? 32'hFFFF : 32'h0010);
    chk("r30_ovf", ovf[3], 1);
    step(1, 1, 0, 3, 0); chk("r30_sticky", ovf[3], 1);
    // clr+valid and clr alone
    step(1, 1, 1, 3, 4); chk("r31_dout", dout, 4); chk("r31_ovf", ovf[3], 0);
    step(1, 0, 1, 0, 77);
    step(1, 1, 0, 0, 1); chk("r31_clr0", dout, 1);
    // out-of-range channel
    step(1, 1, 0, 5, 9);
    step(1, 1, 1, 6, 9); chk("r32_vld", out_valid, 0);
    // reset between two ch0 requests
    step(1, 1, 0, 0, 9);
    step(0, 1, 0, 0, 9);
    step(1, 1, 0, 0, 9); chk("r33_dout", dout, 9); chk("r33_ovf", ovf, 0);
    // back-to-back same channel, no idle
    for (int k = 0; k < 4; k++) step(1, 1, 0, 2, 1000 * (k + 1));

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit r, v, c;
      int ch, d;
      r  = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 9) == 0);
      ch = $urandom_range(0, 5);
      d  = ($urandom_range(0, 2) == 0) ? $urandom_range(65000, 65535) : $urandom_range(0, 65535);
      step(r, v, c, ch, d);
    end

    // read every accumulator back by adding zero
    for (int i = 0; i < CH; i++) step(1, 1, 0, i, 0);
    step(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_fed_multi.md
ACC_FED_MULTI -- requirements
Module: acc_fed_multi

Interface
REQ-001 Parameter WIDTH, default 16: data and accumulator width in bits, unsigned.
REQ-002 Parameter CHANNELS, default 4: number of independent accumulators, range 1..16.
REQ-003 Parameter CHW, default $clog2(CHANNELS) (minimum 1): channel index width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 res  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  din/in_ch qualify an accumulate request this cycle.
REQ-007 in_ch  input  CHW  target channel for in_valid and clr.
REQ-008 din  input  WIDTH  addend.
REQ-009 clr  input  1  zero the channel in_ch and its overflow flag.
REQ-010 out_valid  output  1  dout/out_ch hold a fresh result this cycle.
REQ-011 out_ch  output  CHW  channel that produced dout.
REQ-012 dout  output  WIDTH  updated accumulator value of out_ch.
REQ-013 ovf  output  CHANNELS  sticky per-channel overflow flags.

Function
REQ-014 Accepted request (in_valid=1, in_ch<CHANNELS, clr=0): acc[in_ch] <= acc[in_ch] + din at the edge.
REQ-015 Latency 1: the edge that accepts a request drives out_valid=1, out_ch=in_ch, dout=new acc[in_ch]; no request -> out_valid=0 next cycle, dout/out_ch hold.
REQ-016 Back-to-back requests, same or different channel, accepted every cycle; same-channel consecutive requests use the just-updated value (no hazard, no stall).
REQ-017 clr=1 with in_valid=0: acc[in_ch] <= 0, ovf[in_ch] <= 0, out_valid=0 next cycle.
REQ-018 clr=1 with in_valid=1: acc[in_ch] <= din, ovf[in_ch] <= 0, out_valid=1, dout=din.
REQ-019 in_ch >= CHANNELS: request and clr ignored, no state change, out_valid=0.
REQ-020 Overflow = carry out of the WIDTH-bit add; sets ovf[in_ch] sticky until clr or reset.
REQ-021 Non-addressed channels never change state.

Reset
REQ-022 res=0 at an edge: all acc=0, ovf=0, out_valid=0, out_ch=0, dout=0; reset overrides all inputs.
REQ-023 Reset mid-stream: requests presented during the reset cycle are discarded; first post-reset request accumulates from 0.

Configuration
REQ-024 Macro ACC_FED_SAT_EN defined: an overflowing add stores 2^WIDTH-1 (saturate) and sets ovf.
REQ-025 ACC_FED_SAT_EN undefined: an overflowing add stores (sum mod 2^WIDTH) (wrap) and sets ovf.

Structure
REQ-026 Shared package acc_fed_pkg holds default WIDTH/CHANNELS constants and the sat/wrap select constant.
REQ-027 Per-channel register, adder, sat/wrap logic and ovf flag in one sub-module acc_fed_lane, instantiated CHANNELS times; top holds decode and output mux/register.

Verification
REQ-028 Reset, then ch0: din=12 then din=10 on consecutive cycles -> dout=12 then 22, out_ch=0, out_valid high both cycles.
REQ-029 Interleave ch1 din=5, ch2 din=7, ch1 din=3 -> dout 5, 7, 8; ch0 unchanged at 22.
REQ-030 WIDTH=16, ch3 load 0xFFF0, add 0x0020 -> wrap build: dout=0x0010, ovf[3]=1; ACC_FED_SAT_EN build: dout=0xFFFF, ovf[3]=1; further add 0 keeps ovf[3]=1.
REQ-031 clr+in_valid on ch3, din=4 -> dout=4, ovf[3]=0; clr alone on ch0 -> next ch0 din=1 gives dout=1.
REQ-032 in_ch=5 with CHANNELS=4, in_valid=1 -> out_valid=0, no acc/ovf change.
REQ-033 res=0 asserted for one cycle between two ch0 requests of 9 -> second result dout=9, all ovf=0.
